// File: rtl/bypass_ctrl_pkg.sv
// Shared defaults, zero-register address and shadow-entry field layout for bypass_ctrl.
// Optional statistics counters are enabled with the BYPASS_STATS_EN macro (see bypass_ctrl.sv).
package bypass_ctrl_pkg;
  localparam int DW_DEF    = 32;
  localparam int AW_DEF    = 5;
  localparam int DEPTH_DEF = 3;
  localparam int N_RD_DEF  = 2;
  localparam int LATE_DEF  = 1;
  localparam int ZERO_REG  = 0;

  // Entry layout, LSB first: late, wd[AW], wreg, v
  localparam int E_LATE = 0;
  localparam int E_WD   = 1;

  function automatic int e_wreg(input int aw);
    return aw + 1;
  endfunction

  function automatic int e_v(input int aw);
    return aw + 2;
  endfunction

  function automatic int e_width(input int aw);
    return aw + 3;
  endfunction
endpackage

// File: rtl/bypass_ctrl_if.sv
// ID-side bundle of bypass_ctrl: issue, read ports, stage results and resolved operands.
// Feature macro BYPASS_STATS_EN controls whether the counter outputs carry live values.
interface bypass_ctrl_if #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 3,
  parameter int N_RD  = 2
);
  // Issue handshake: an instruction enters EX on a clock edge only when iss_valid=1 and
  // stall_o=0 (and no hold/flush); stall_o is the inverted ready, valid in the same cycle.
  logic              iss_valid;
  logic              iss_wreg;
  logic [AW-1:0]     iss_wd;
  logic              iss_late;
  logic              hold_i;
  logic              flush_i;
  logic [N_RD-1:0]   rd_en;
  logic [N_RD*AW-1:0] rd_addr;
  logic [N_RD*DW-1:0] rf_data;
  logic [DEPTH*DW-1:0] st_wdata;
  logic [N_RD*DW-1:0] opnd_o;
  logic              stall_o;
  logic [31:0]       stall_cnt_o;
  logic [31:0]       fwd_cnt_o;

  modport master (
    output iss_valid, iss_wreg, iss_wd, iss_late, hold_i, flush_i,
    output rd_en, rd_addr, rf_data, st_wdata,
    input  opnd_o, stall_o, stall_cnt_o, fwd_cnt_o
  );

  modport slave (
    input  iss_valid, iss_wreg, iss_wd, iss_late, hold_i, flush_i,
    input  rd_en, rd_addr, rf_data, st_wdata,
    output opnd_o, stall_o, stall_cnt_o, fwd_cnt_o
  );
endinterface

// File: rtl/bypass_sel.sv
// One read port: youngest-match search over the shadow entries, operand mux and readiness.
// Used by bypass_ctrl (BYPASS_STATS_EN has no effect here).
module bypass_sel
  import bypass_ctrl_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int LATE  = LATE_DEF
) (
  input  logic [DEPTH*e_width(AW)-1:0] ent,
  input  logic                         en,
  input  logic [AW-1:0]                addr,
  input  logic [DW-1:0]                rf,
  input  logic [DEPTH*DW-1:0]          st,
  output logic [DW-1:0]                opnd,
  output logic                         hit,
  output logic                         rdy
);
  localparam int EW = e_width(AW);

  logic [DW-1:0] data;
  logic          zero;

  assign zero = !en || (addr == AW'(ZERO_REG));

  always_comb begin
    hit  = 1'b0;
    rdy  = 1'b0;
    data = '0;
    // Scan oldest to youngest so the youngest match is the one left standing.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent[i*EW + e_v(AW)] && ent[i*EW + e_wreg(AW)] &&
          (ent[i*EW + E_WD +: AW] == addr)) begin
        hit  = 1'b1;
        rdy  = !ent[i*EW + E_LATE] || (i >= LATE);
        data = st[i*DW +: DW];
      end
    end
    if (zero) begin
      hit = 1'b0;
    end
  end

  always_comb begin
    opnd = rf;
    if (zero) begin
      opnd = '0;
    end else if (hit && rdy) begin
      opnd = data;
    end
  end
endmodule

// File: rtl/bypass_ctrl.sv
// Operand bypass and load-use stall unit: shadow tag shift register plus per-port selectors.
// Define BYPASS_STATS_EN to build the stall/forward counters; otherwise they read as 0.
module bypass_ctrl
  import bypass_ctrl_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int N_RD  = N_RD_DEF,
  parameter int LATE  = LATE_DEF
) (
  input logic          clk,
  input logic          rst,
  bypass_ctrl_if.slave bus
);
  localparam int EW = e_width(AW);

  logic [DEPTH*EW-1:0] ent;
  logic [EW-1:0]       new_e;
  logic [N_RD-1:0]     hit;
  logic [N_RD-1:0]     rdy;
  logic [DW-1:0]       opnd [N_RD];
  logic                stall;

  for (genvar p = 0; p < N_RD; p++) begin : g_port
    bypass_sel #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .LATE(LATE)) u_sel (
      .ent  (ent),
      .en   (bus.rd_en[p]),
      .addr (bus.rd_addr[p*AW +: AW]),
      .rf   (bus.rf_data[p*DW +: DW]),
      .st   (bus.st_wdata),
      .opnd (opnd[p]),
      .hit  (hit[p]),
      .rdy  (rdy[p])
    );
    assign bus.opnd_o[p*DW +: DW] = opnd[p];
  end

  assign stall       = |(hit & ~rdy);
  assign bus.stall_o = stall;

  always_comb begin
    new_e                = '0;
    new_e[e_v(AW)]       = bus.iss_valid && !stall;
    new_e[e_wreg(AW)]    = bus.iss_wreg;
    new_e[E_WD +: AW]    = bus.iss_wd;
    new_e[E_LATE]        = bus.iss_late;
  end

  // Entry 0 (EX) sits in the low bits; a shift moves every entry one stage older.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent <= '0;
    end else if (bus.flush_i) begin
      ent <= '0;
    end else if (!bus.hold_i) begin
      ent <= {ent[(DEPTH-1)*EW-1:0], new_e};
    end
  end

`ifdef BYPASS_STATS_EN
  logic [31:0] stall_cnt;
  logic [31:0] fwd_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (!bus.hold_i && stall) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      fwd_cnt <= fwd_cnt + 32'($countones(hit & rdy));
    end
  end

  assign bus.stall_cnt_o = stall_cnt;
  assign bus.fwd_cnt_o   = fwd_cnt;
`else
  assign bus.stall_cnt_o = '0;
  assign bus.fwd_cnt_o   = '0;
`endif
endmodule

// File: tb/tb_bypass_ctrl.sv
// Testbench for bypass_ctrl: directed scenarios plus randomized traffic against a tag-list model.
// Counter expectations follow BYPASS_STATS_EN.
module tb_bypass_ctrl;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 3;
  localparam int N_RD  = 2;
  localparam int LATE  = 1;
`ifdef BYPASS_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk;
  logic rst;
  int   total;
  int   bad;

  bypass_ctrl_if #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .N_RD(N_RD)) bus ();

  bypass_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .N_RD(N_RD), .LATE(LATE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model: list of in-flight writes, index 0 = youngest ----------------
  bit            m_v    [DEPTH];
  bit            m_wreg [DEPTH];
  int            m_wd   [DEPTH];
  bit            m_late [DEPTH];
  logic [31:0]   m_scnt;
  logic [31:0]   m_fcnt;

  function automatic int m_idx(int p);
    int a;
    a = int'(bus.rd_addr[p*AW +: AW]);
    if (!bus.rd_en[p] || a == 0) return -1;
    for (int i = 0; i < DEPTH; i++)
      if (m_v[i] && m_wreg[i] && m_wd[i] == a) return i;
    return -1;
  endfunction

  function automatic bit m_ready(int i);
    return !m_late[i] || i >= LATE;
  endfunction

  function automatic bit m_port_stall(int p);
    int i;
    i = m_idx(p);
    return (i >= 0) && !m_ready(i);
  endfunction

  function automatic bit m_stall();
    bit s;
    s = 1'b0;
    for (int p = 0; p < N_RD; p++) s |= m_port_stall(p);
    return s;
  endfunction

  function automatic int m_fwd_num();
    int n;
    int i;
    n = 0;
    for (int p = 0; p < N_RD; p++) begin
      i = m_idx(p);
      if (i >= 0 && m_ready(i)) n++;
    end
    return n;
  endfunction

  function automatic logic [DW-1:0] m_opnd(int p);
    int i;
    if (!bus.rd_en[p] || bus.rd_addr[p*AW +: AW] == '0) return '0;
    i = m_idx(p);
    if (i < 0) return bus.rf_data[p*DW +: DW];
    return bus.st_wdata[i*DW +: DW];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle();
    bus.iss_valid = 1'b0;
    bus.iss_wreg  = 1'b0;
    bus.iss_wd    = '0;
    bus.iss_late  = 1'b0;
    bus.hold_i    = 1'b0;
    bus.flush_i   = 1'b0;
    bus.rd_en     = '0;
    bus.rd_addr   = '0;
    bus.rf_data   = {32'hF1F1_0001, 32'hF0F0_0000};
    bus.st_wdata  = {32'h0000_0033, 32'h0000_0022, 32'h0000_0011};
  endtask

  task automatic issue(bit valid, bit wreg, int wd, bit late);
    bus.iss_valid = valid;
    bus.iss_wreg  = wreg;
    bus.iss_wd    = AW'(wd);
    bus.iss_late  = late;
  endtask

  task automatic set_rd(int p, bit en, int addr);
    bus.rd_en[p]             = en;
    bus.rd_addr[p*AW +: AW]  = AW'(addr);
  endtask

  // One clock edge; model advances using the values seen just before the edge.
  task automatic tick();
    bit st;
    int nf;
    st = m_stall();
    nf = m_fwd_num();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) m_v[i] = 1'b0;
      m_scnt = '0;
      m_fcnt = '0;
    end else begin
      if (!bus.hold_i && st) m_scnt = m_scnt + 32'd1;
      m_fcnt = m_fcnt + 32'(nf);
      if (bus.flush_i) begin
        for (int i = 0; i < DEPTH; i++) m_v[i] = 1'b0;
      end else if (!bus.hold_i) begin
        for (int i = DEPTH - 1; i > 0; i--) begin
          m_v[i] = m_v[i-1]; m_wreg[i] = m_wreg[i-1];
          m_wd[i] = m_wd[i-1]; m_late[i] = m_late[i-1];
        end
        m_v[0]    = bus.iss_valid && !st;
        m_wreg[0] = bus.iss_wreg;
        m_wd[0]   = int'(bus.iss_wd);
        m_late[0] = bus.iss_late;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle();
    rst = 1'b1;
    set_rd(0, 1, 3);
    set_rd(1, 1, 4);
    bus.rf_data = {32'h0000_4444, 32'h0000_3333};
    tick();
    tick();
    #1;
    total++;
    if (bus.stall_o !== 1'b0) begin
      bad++; $display("FAIL reset_stall got=%b exp=0", bus.stall_o);
    end
    total++;
    if (bus.opnd_o !== {32'h0000_4444, 32'h0000_3333}) begin
      bad++; $display("FAIL reset_opnd got=%h exp=%h", bus.opnd_o, {32'h0000_4444, 32'h0000_3333});
    end
    rst = 1'b0;
    tick();
    #1;
    total++;
    if (bus.stall_cnt_o !== 32'd0 || bus.fwd_cnt_o !== 32'd0) begin
      bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", bus.stall_cnt_o, bus.fwd_cnt_o);
    end
  endtask

  task automatic test_alu_forward();
    logic [DW-1:0] exp_q [$];
    do_reset();
    issue(1, 1, 3, 0);
    tick();
    issue(0, 0, 0, 0);
    set_rd(0, 1, 3);
    exp_q = '{32'h11, 32'h22, 32'h33, 32'hF0F0_0000};
    for (int k = 0; k < 4; k++) begin
      #1;
      total++;
      if (bus.opnd_o[0 +: DW] !== exp_q[k] || bus.stall_o !== 1'b0) begin
        bad++; $display("FAIL alu_fwd_%0d got=%h stall=%b exp=%h", k, bus.opnd_o[0 +: DW], bus.stall_o, exp_q[k]);
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    int stall_cycles;
    do_reset();
    issue(1, 1, 5, 1);
    tick();
    issue(1, 1, 9, 0);
    set_rd(0, 1, 5);
    stall_cycles = 0;
    #1;
    total++;
    if (bus.stall_o !== 1'b1) begin
      bad++; $display("FAIL load_use_stall got=%b exp=1", bus.stall_o);
    end
    while (bus.stall_o === 1'b1 && stall_cycles < 8) begin
      stall_cycles++;
      tick();
      #1;
    end
    total++;
    if (stall_cycles != 1) begin
      bad++; $display("FAIL load_use_len got=%0d exp=1", stall_cycles);
    end
    total++;
    if (bus.opnd_o[0 +: DW] !== 32'h22) begin
      bad++; $display("FAIL load_use_opnd got=%h exp=%h", bus.opnd_o[0 +: DW], 32'h22);
    end
    tick();
    #1;
    total++;
    if (bus.opnd_o[0 +: DW] !== 32'h33) begin
      bad++; $display("FAIL load_use_bubble got=%h exp=%h", bus.opnd_o[0 +: DW], 32'h33);
    end
  endtask

  task automatic test_youngest();
    do_reset();
    bus.st_wdata = {32'h0000_00CC, 32'h0000_00BB, 32'h0000_00AA};
    issue(1, 1, 7, 0);
    tick();
    issue(1, 1, 7, 0);
    tick();
    issue(0, 0, 0, 0);
    set_rd(1, 1, 7);
    #1;
    total++;
    if (bus.opnd_o[DW +: DW] !== 32'hAA) begin
      bad++; $display("FAIL youngest_alu got=%h exp=%h", bus.opnd_o[DW +: DW], 32'hAA);
    end
    do_reset();
    issue(1, 1, 7, 0);
    tick();
    issue(1, 1, 7, 1);
    tick();
    issue(0, 0, 0, 0);
    set_rd(1, 1, 7);
    #1;
    total++;
    if (bus.stall_o !== 1'b1) begin
      bad++; $display("FAIL youngest_load_stall got=%b exp=1", bus.stall_o);
    end
  endtask

  task automatic test_zero_reg();
    do_reset();
    issue(1, 1, 0, 1);
    tick();
    issue(0, 0, 0, 0);
    set_rd(0, 1, 0);
    set_rd(1, 1, 0);
    #1;
    total++;
    if (bus.opnd_o !== '0 || bus.stall_o !== 1'b0) begin
      bad++; $display("FAIL zero_reg got=%h stall=%b exp=0 stall=0", bus.opnd_o, bus.stall_o);
    end
  endtask

  task automatic test_flush_rst();
    for (int mode = 0; mode < 2; mode++) begin
      do_reset();
      issue(1, 1, 5, 1);
      tick();
      issue(1, 1, 9, 0);
      set_rd(0, 1, 5);
      #1;
      total++;
      if (bus.stall_o !== 1'b1) begin
        bad++; $display("FAIL flush_pre_%0d got=%b exp=1", mode, bus.stall_o);
      end
      if (mode == 0) bus.flush_i = 1'b1;
      else rst = 1'b1;
      tick();
      bus.flush_i = 1'b0;
      rst = 1'b0;
      #1;
      total++;
      if (bus.stall_o !== 1'b0 || bus.opnd_o[0 +: DW] !== 32'hF0F0_0000) begin
        bad++; $display("FAIL flush_post_%0d got=%h stall=%b exp=%h stall=0", mode, bus.opnd_o[0 +: DW], bus.stall_o, 32'hF0F0_0000);
      end
    end
  endtask

  task automatic test_hold();
    do_reset();
    issue(1, 1, 5, 1);
    tick();
    issue(1, 1, 9, 0);
    set_rd(0, 1, 5);
    bus.hold_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if (bus.stall_o !== 1'b1 || bus.stall_cnt_o !== 32'd0) begin
        bad++; $display("FAIL hold_%0d got stall=%b cnt=%0d exp stall=1 cnt=0", k, bus.stall_o, bus.stall_cnt_o);
      end
      tick();
    end
    bus.hold_i = 1'b0;
    #1;
    total++;
    if (bus.stall_o !== 1'b1) begin
      bad++; $display("FAIL hold_release_stall got=%b exp=1", bus.stall_o);
    end
    tick();
    #1;
    total++;
    if (bus.stall_o !== 1'b0 || bus.stall_cnt_o !== (STATS ? 32'd1 : 32'd0)) begin
      bad++; $display("FAIL hold_after got stall=%b cnt=%0d exp stall=0 cnt=%0d", bus.stall_o, bus.stall_cnt_o, STATS ? 1 : 0);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] exp_q [$];
    do_reset();
    for (int c = 0; c < 500; c++) begin
      issue($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, $urandom_range(0, 4), $urandom_range(0, 1) == 1);
      bus.hold_i  = ($urandom_range(0, 7) == 0);
      bus.flush_i = ($urandom_range(0, 19) == 0);
      rst         = ($urandom_range(0, 99) == 0);
      for (int p = 0; p < N_RD; p++) set_rd(p, $urandom_range(0, 3) != 0, $urandom_range(0, 4));
      bus.rf_data  = {$urandom, $urandom};
      bus.st_wdata = {$urandom, $urandom, $urandom};
      #1;
      exp_q.delete();
      for (int p = 0; p < N_RD; p++) exp_q.push_back(m_opnd(p));
      for (int p = 0; p < N_RD; p++) begin
        if (!m_port_stall(p)) begin
          total++;
          if (bus.opnd_o[p*DW +: DW] !== exp_q[p]) begin
            bad++; $display("FAIL rand_opnd c=%0d p=%0d got=%h exp=%h", c, p, bus.opnd_o[p*DW +: DW], exp_q[p]);
          end
        end
      end
      total++;
      if (bus.stall_o !== m_stall()) begin
        bad++; $display("FAIL rand_stall c=%0d got=%b exp=%b", c, bus.stall_o, m_stall());
      end
      total++;
      if (bus.stall_cnt_o !== (STATS ? m_scnt : 32'd0) || bus.fwd_cnt_o !== (STATS ? m_fcnt : 32'd0)) begin
        bad++; $display("FAIL rand_cnt c=%0d got=%0d/%0d exp=%0d/%0d", c, bus.stall_cnt_o, bus.fwd_cnt_o,
                        STATS ? m_scnt : 32'd0, STATS ? m_fcnt : 32'd0);
      end
      tick();
    end
    rst = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    total = 0;
    bad   = 0;
    m_scnt = '0;
    m_fcnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      m_v[i] = 1'b0; m_wreg[i] = 1'b0; m_wd[i] = 0; m_late[i] = 1'b0;
    end
    rst = 1'b1;
    idle();
    @(negedge clk);
    test_reset();
    test_alu_forward();
    test_load_use();
    test_youngest();
    test_zero_reg();
    test_flush_rst();
    test_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
